// File: rtl/lap_stop_watch_pkg.sv
// Shared types and helpers for the lap stopwatch: FSM state encoding,
// seconds limit, BCD digit width and the tens/units splitter.
package stop_watch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } sw_state_e;

   localparam int SEC_MAX = 59;
   localparam int BCD_W   = 4;

   typedef struct packed {
      logic [BCD_W-1:0] tens;
      logic [BCD_W-1:0] units;
   } bcd_pair_t;

   // Values never exceed 99, so both digits fit in one BCD nibble each.
   function automatic bcd_pair_t split_bcd(input logic [6:0] val);
      bcd_pair_t r;
      r.tens  = BCD_W'(val / 7'd10);
      r.units = BCD_W'(val % 7'd10);
      return r;
   endfunction

endpackage

// File: rtl/lap_stop_watch_if.sv
// Control inputs and display/status outputs of the lap stopwatch.
interface lap_stop_watch_if #(
   parameter int LAP_DEPTH = 4
);
   localparam int CNT_W = $clog2(LAP_DEPTH + 1);

   logic             enb;
   logic             sw2;
   logic             btn_run;
   logic             btn_lap;
   logic             lap_rd;
   logic [3:0]       sw_min1;
   logic [3:0]       sw_min2;
   logic [3:0]       sw_sec1;
   logic [3:0]       sw_sec2;
   logic [3:0]       lap_min1;
   logic [3:0]       lap_min2;
   logic [3:0]       lap_sec1;
   logic [3:0]       lap_sec2;
   logic             lap_valid;
   logic [CNT_W-1:0] lap_count;
   logic             lap_ovf;
   logic             rolled;
   logic             running;

   modport master (
      output enb, sw2, btn_run, btn_lap, lap_rd,
      input  sw_min1, sw_min2, sw_sec1, sw_sec2,
      input  lap_min1, lap_min2, lap_sec1, lap_sec2,
      input  lap_valid, lap_count, lap_ovf, rolled, running
   );

   modport slave (
      input  enb, sw2, btn_run, btn_lap, lap_rd,
      output sw_min1, sw_min2, sw_sec1, sw_sec2,
      output lap_min1, lap_min2, lap_sec1, lap_sec2,
      output lap_valid, lap_count, lap_ovf, rolled, running
   );
endinterface

// File: rtl/edgeDetector.sv
// Rising-edge detector: an edge sampled at one clock produces a one-cycle
// registered pulse that the consumer acts on at the following clock.
module edgeDetector (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   output logic pulse
);
   logic sig_q;

   // Remember the previous sample and flag a 0->1 transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= 1'b0;
         pulse <= 1'b0;
      end else begin
         sig_q <= sig;
         pulse <= sig & ~sig_q;
      end
   end
endmodule

// File: rtl/lap_stop_watch_lap_fifo.sv
// Lap capture FIFO. A push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle; otherwise it is silently dropped and the
// caller decides whether that counts as overflow.
module lap_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 13
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clear,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty && !clear;
   assign do_push = push && !clear && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; clear empties the FIFO outright.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= bump(wr_ptr);
         if (do_pop)  rd_ptr <= bump(rd_ptr);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end

   // Entry storage; contents are masked by the occupancy count, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/lap_stop_watch.sv
// MM:SS stopwatch with run/pause control, lap capture FIFO and sticky
// rollover/overflow flags, driving BCD digits to the display mux.
//
// state | meaning
// IDLE  | counters cleared, waiting for a run event
// RUN   | counting 1 Hz ticks, lap events capture the current time
// PAUSE | counters frozen, run resumes, lap clears everything
module lap_stop_watch
   import stop_watch_pkg::*;
#(
   parameter int MAX_MIN   = 99,
   parameter int LAP_DEPTH = 4
) (
   input logic             clk,
   input logic             rst_n,
   lap_stop_watch_if.slave bus
);
   localparam int MIN_W = $clog2(MAX_MIN + 1);
   localparam int LAP_W = MIN_W + 6;
   localparam int CNT_W = $clog2(LAP_DEPTH + 1);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_RUN   = RUN;
   localparam logic [1:0] S_PAUSE = PAUSE;

   logic [1:0]       state;
   logic [1:0]       state_nx;
   logic [5:0]       sec;
   logic [MIN_W-1:0] min;
   logic             run_ev;
   logic             lap_ev;
   logic             act_run;
   logic             act_lap;
   logic             do_clear;
   logic             do_capture;
   logic             do_tick;
   logic             do_pop;
   logic [LAP_W-1:0] lap_head;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   bcd_pair_t        min_bcd;
   bcd_pair_t        sec_bcd;
   bcd_pair_t        lmin_bcd;
   bcd_pair_t        lsec_bcd;

   edgeDetector u_run_edge (.clk(clk), .rst_n(rst_n), .sig(bus.btn_run), .pulse(run_ev));
   edgeDetector u_lap_edge (.clk(clk), .rst_n(rst_n), .sig(bus.btn_lap), .pulse(lap_ev));

   // A run event always beats a lap event arriving in the same cycle.
   assign act_run    = bus.sw2 && run_ev;
   assign act_lap    = bus.sw2 && lap_ev && !run_ev;
   assign do_clear   = act_lap && (state != S_RUN);
   assign do_capture = act_lap && (state == S_RUN);
   assign do_tick    = bus.sw2 && bus.enb && (state == S_RUN);
   assign do_pop     = bus.sw2 && bus.lap_rd && !do_clear;

   // Next-state decode.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (act_run) state_nx = S_RUN;
         S_RUN:   if (act_run) state_nx = S_PAUSE;
         S_PAUSE: begin
            if (act_run)      state_nx = S_RUN;
            else if (act_lap) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // State register; running is loaded alongside so it tracks the state exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         bus.running <= 1'b0;
      end else begin
         state       <= state_nx;
         bus.running <= (state_nx == S_RUN);
      end
   end

   // MM:SS counter with wrap after MAX_MIN:59 and sticky rollover flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sec        <= '0;
         min        <= '0;
         bus.rolled <= 1'b0;
      end else if (do_clear) begin
         sec        <= '0;
         min        <= '0;
         bus.rolled <= 1'b0;
      end else if (do_tick) begin
         if (sec == 6'(SEC_MAX)) begin
            sec <= '0;
            if (min == MIN_W'(MAX_MIN)) begin
               min        <= '0;
               bus.rolled <= 1'b1;
            end else begin
               min <= min + MIN_W'(1);
            end
         end else begin
            sec <= sec + 6'd1;
         end
      end
   end

   // Sticky overflow: a capture into a full buffer with no pop to make room.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   bus.lap_ovf <= 1'b0;
      else if (do_clear)                            bus.lap_ovf <= 1'b0;
      else if (do_capture && fifo_full && !do_pop) bus.lap_ovf <= 1'b1;
   end

   lap_fifo #(.DEPTH(LAP_DEPTH), .WIDTH(LAP_W)) u_lap_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (do_capture),
      .pop   (do_pop),
      .clear (do_clear),
      .din   ({min, sec}),
      .head  (lap_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign min_bcd  = split_bcd(7'(min));
   assign sec_bcd  = split_bcd(7'(sec));
   assign lmin_bcd = split_bcd(7'(lap_head[LAP_W-1:6]));
   assign lsec_bcd = split_bcd(7'(lap_head[5:0]));

   // Registered display and lap status; frozen while the mode is deselected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.sw_min1   <= '0;
         bus.sw_min2   <= '0;
         bus.sw_sec1   <= '0;
         bus.sw_sec2   <= '0;
         bus.lap_min1  <= '0;
         bus.lap_min2  <= '0;
         bus.lap_sec1  <= '0;
         bus.lap_sec2  <= '0;
         bus.lap_valid <= 1'b0;
         bus.lap_count <= '0;
      end else if (bus.sw2) begin
         bus.sw_min1   <= min_bcd.tens;
         bus.sw_min2   <= min_bcd.units;
         bus.sw_sec1   <= sec_bcd.tens;
         bus.sw_sec2   <= sec_bcd.units;
         bus.lap_min1  <= fifo_empty ? '0 : lmin_bcd.tens;
         bus.lap_min2  <= fifo_empty ? '0 : lmin_bcd.units;
         bus.lap_sec1  <= fifo_empty ? '0 : lsec_bcd.tens;
         bus.lap_sec2  <= fifo_empty ? '0 : lsec_bcd.units;
         bus.lap_valid <= !fifo_empty;
         bus.lap_count <= fifo_count;
      end
   end
endmodule

// File: tb/tb_lap_stop_watch.sv
// Directed bench for lap_stop_watch with MAX_MIN=2, LAP_DEPTH=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_lap_stop_watch;
   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   lap_stop_watch_if #(.LAP_DEPTH(4)) bus ();

   lap_stop_watch #(.MAX_MIN(2), .LAP_DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int sw_digits();
      return {bus.sw_min1, bus.sw_min2, bus.sw_sec1, bus.sw_sec2};
   endfunction

   function automatic int lap_digits();
      return {bus.lap_min1, bus.lap_min2, bus.lap_sec1, bus.lap_sec2};
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         bus.enb = 1'b1; step();
         bus.enb = 1'b0; step();
      end
   endtask

   // Edge at the first clock, action at the second, outputs settle at the third.
   task automatic press_run();
      bus.btn_run = 1'b1; step();
      bus.btn_run = 1'b0; step();
      step();
   endtask

   task automatic press_lap();
      bus.btn_lap = 1'b1; step();
      bus.btn_lap = 1'b0; step();
      step();
   endtask

   task automatic press_lap_rd();
      bus.btn_lap = 1'b1; step();
      bus.btn_lap = 1'b0; bus.lap_rd = 1'b1; step();
      bus.lap_rd = 1'b0; step();
   endtask

   task automatic press_with_tick(input logic both);
      bus.btn_run = 1'b1; bus.btn_lap = both; step();
      bus.btn_run = 1'b0; bus.btn_lap = 1'b0; bus.enb = 1'b1; step();
      bus.enb = 1'b0; step();
   endtask

   task automatic pop(input int n);
      bus.lap_rd = 1'b1;
      repeat (n) step();
      bus.lap_rd = 1'b0;
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      bus.enb = 1'b0; bus.sw2 = 1'b1; bus.btn_run = 1'b0;
      bus.btn_lap = 1'b0; bus.lap_rd = 1'b0;
      repeat (3) step();
      check("rst_sw_digits", sw_digits(), 'h0000);
      check("rst_lap_digits", lap_digits(), 'h0000);
      check("rst_flags", {bus.lap_valid, bus.lap_ovf, bus.rolled, bus.running}, 0);
      check("rst_lap_count", bus.lap_count, 0);
      rst_n = 1'b1;
      step();

      // Start and count 125 s.
      press_run();
      check("start_running", bus.running, 1);
      ticks(125);
      check("count_0205", sw_digits(), 'h0205);
      check("count_running", bus.running, 1);

      // Run to MAX_MIN:59 then wrap.
      ticks(54);
      check("count_0259", sw_digits(), 'h0259);
      check("pre_wrap_rolled", bus.rolled, 0);
      ticks(1);
      check("wrap_digits", sw_digits(), 'h0000);
      check("wrap_rolled", bus.rolled, 1);
      press_run();
      check("pause_running", bus.running, 0);
      press_lap();
      check("clear_rolled", bus.rolled, 0);
      check("clear_running", bus.running, 0);

      // Lap captures at 3,7,9,12 then an overflowing capture at 15.
      press_run();
      ticks(3); press_lap();
      ticks(4); press_lap();
      ticks(2); press_lap();
      ticks(3); press_lap();
      check("full_count", bus.lap_count, 4);
      check("full_no_ovf", bus.lap_ovf, 0);
      ticks(3); press_lap();
      check("ovf_count", bus.lap_count, 4);
      check("ovf_flag", bus.lap_ovf, 1);
      check("ovf_head", lap_digits(), 'h0003);
      check("ovf_valid", bus.lap_valid, 1);
      pop(2);
      check("pop2_head", lap_digits(), 'h0009);
      check("pop2_count", bus.lap_count, 2);

      // Clear, refill, then capture plus pop on a full buffer.
      press_run();
      press_lap();
      check("clr_count", bus.lap_count, 0);
      check("clr_valid", bus.lap_valid, 0);
      check("clr_ovf", bus.lap_ovf, 0);
      check("clr_lap_digits", lap_digits(), 'h0000);
      check("clr_sw_digits", sw_digits(), 'h0000);
      press_run();
      for (int i = 0; i < 4; i++) begin
         ticks(1); press_lap();
      end
      check("refill_count", bus.lap_count, 4);
      ticks(1);
      press_lap_rd();
      check("push_pop_count", bus.lap_count, 4);
      check("push_pop_ovf", bus.lap_ovf, 0);
      check("push_pop_head", lap_digits(), 'h0002);

      // Run+lap together in RUN: pause, no capture, tick counted.
      press_with_tick(1'b1);
      check("both_digits", sw_digits(), 'h0006);
      check("both_running", bus.running, 0);
      check("both_count", bus.lap_count, 4);
      check("both_head", lap_digits(), 'h0002);
      ticks(1);
      check("paused_hold", sw_digits(), 'h0006);
      press_with_tick(1'b0);
      check("resume_tick_dropped", sw_digits(), 'h0006);
      check("resume_running", bus.running, 1);

      // Mid-run reset at 01:30 with 3 laps stored.
      press_run();
      press_lap();
      press_run();
      for (int i = 0; i < 3; i++) begin
         ticks(1); press_lap();
      end
      ticks(87);
      check("pre_rst_digits", sw_digits(), 'h0130);
      check("pre_rst_count", bus.lap_count, 3);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_sw", sw_digits(), 'h0000);
      check("async_rst_lap", lap_digits(), 'h0000);
      check("async_rst_count", bus.lap_count, 0);
      check("async_rst_flags", {bus.lap_valid, bus.running}, 0);
      step();
      rst_n = 1'b1;
      step();
      ticks(1);
      check("post_rst_idle", sw_digits(), 'h0000);
      press_run();
      check("post_rst_run", bus.running, 1);

      // Mode deselected: tick and run edge are ignored.
      bus.sw2 = 1'b0;
      ticks(1);
      press_run();
      bus.sw2 = 1'b1;
      step();
      check("sw2_low_digits", sw_digits(), 'h0000);
      check("sw2_low_running", bus.running, 1);
      ticks(1);
      check("sw2_high_count", sw_digits(), 'h0001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/lap_stop_watch.md
# lap_stop_watch

Parametrised next-generation stopwatch for the digital clock: counts MM:SS from a 1 Hz enable, with start/stop/resume control through a three-state FSM. Adds a lap-capture buffer of configurable depth, a configurable minute limit, and status flags. It sits beside the clock and alarm blocks and drives the display mux with BCD digits, as the current stopwatch does.

## Interface
- `MAX_MIN`, default 99: last minute value before wrap to 00:00. Legal range 1..99.
- `LAP_DEPTH`, default 4: number of lap entries held. Legal range 1..16.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enb` in 1: 1 Hz tick, one `clk` cycle wide.
- `sw2` in 1: stopwatch mode enable. When low, the block holds all state.
- `btn_run` in 1: raw start/stop button. A rising edge is a run event.
- `btn_lap` in 1: raw lap/clear button. A rising edge is a lap event.
- `lap_rd` in 1: pop the oldest lap. Level-sampled, one pop per cycle it is high.
- `sw_min1`, `sw_min2`, `sw_sec1`, `sw_sec2` out 4 each: live BCD digits.
- `lap_min1`, `lap_min2`, `lap_sec1`, `lap_sec2` out 4 each: BCD digits of the oldest lap. 0 when the buffer is empty.
- `lap_valid` out 1: buffer non-empty.
- `lap_count` out `$clog2(LAP_DEPTH+1)`: number of entries stored.
- `lap_ovf` out 1: sticky. Set when a lap is dropped because the buffer is full.
- `rolled` out 1: sticky. Set when the counter wraps from MAX_MIN:59.
- `running` out 1: high in state RUN.

## Operation
- Counters:
  - `sec` is 6 bits, range 0..59.
  - `min` is `$clog2(MAX_MIN+1)` bits, range 0..MAX_MIN.
- FSM states: IDLE (counters zero), RUN, PAUSE. Reset state is IDLE.
  - IDLE, run event → RUN.
  - RUN, run event → PAUSE.
  - RUN, lap event → capture `{min,sec}`; state stays RUN.
  - PAUSE, run event → RUN.
  - PAUSE, lap event → clear counters, lap buffer, `lap_ovf` and `rolled`; go to IDLE.
  - IDLE, lap event → same clear action; state stays IDLE.
- Counting:
  - On `enb` while the current state is RUN: `sec` increments.
  - At `sec` = 59, `sec` goes to 0 and `min` increments.
  - At MAX_MIN:59, both counters go to 00:00 and `rolled` is set.
- Simultaneous events:
  - Run event and lap event in the same cycle: the run event wins and the lap event is discarded.
  - `enb` in the cycle a RUN→PAUSE transition occurs is counted.
  - `enb` in the cycle an IDLE/PAUSE→RUN transition occurs is not counted.
  - A lap captured in the same cycle as a tick stores the pre-increment value.
- Lap buffer is a FIFO:
  - Capture while full: the entry is dropped, `lap_ovf` is set, and contents are unchanged.
  - `lap_rd` while empty: ignored.
  - Capture and `lap_rd` in the same cycle while non-empty: both happen and `lap_count` is unchanged.
  - Capture and `lap_rd` in the same cycle while full: the pop happens and the capture is stored. This does not count as overflow.
  - Clear action in the same cycle as `lap_rd`: clear wins.
- `sw2` low:
  - FSM, counters, buffer and flags hold.
  - `lap_rd`, `enb` and button edges are ignored. Edges occurring while low are lost.
  - Digit outputs hold their last values.
- Digits:
  - `sw_min1` = `min`/10, `sw_min2` = `min`%10, and the same split for `sec`.
  - Lap digits use the same split applied to the FIFO head.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State IDLE; counters 0; buffer empty.
  - All digit outputs 0; `lap_valid`, `lap_count`, `lap_ovf`, `rolled` and `running` are 0.
  - Reset mid-run aborts immediately, with no partial capture.
- Button path: a raw edge sampled at cycle n produces an event pulse at n+1. The FSM and buffer act at the n+1 clock edge.
- Counters update at the clock edge after a qualifying `enb`. `sw_*` digits follow 1 cycle later (registered).
- Capture at edge k: `lap_count`, `lap_valid` and the head digits reflect it at edge k+1. Head digits are registered.
- Pop at edge k: the next head appears at edge k+1.
- `running` is registered from the FSM state, so it is valid in the same cycle as the state.

## Structure
- Package `stop_watch_pkg`:
  - FSM state enum {IDLE, RUN, PAUSE}.
  - `SEC_MAX` = 59.
  - BCD digit width of 4.
  - Function splitting a 7-bit value into tens and units.
- Sub-module `lap_fifo`, parameterised by `DEPTH` and `WIDTH`.
  - Ports: push, pop, clear, data in, head out, count, full, empty.
  - Asynchronous active-low reset.
- The two button edge detectors reuse the existing `edgeDetector` module.

## Test plan
- Reset, then start, then 125 ticks → `sw_*` = 0,2,0,5 one cycle after the last tick; `running` = 1.
- MAX_MIN=2: run to 02:59, then one tick → 00:00 with `rolled` = 1. A lap event in PAUSE then clears `rolled` and returns to IDLE.
- LAP_DEPTH=4: capture at 00:03, 00:07, 00:09, 00:12, 00:15 → `lap_count` = 4 and `lap_ovf` = 1. Head is 00:03; after 2 pops, head is 00:09.
- Full buffer: capture with `lap_rd` in the same cycle → count stays 4 and `lap_ovf` stays 0.
- Run and lap edges in the same cycle while in RUN → state PAUSE and no capture. `enb` in that cycle is counted.
- `rst_n` asserted mid-count at 01:30 with 3 laps stored → all outputs 0 immediately; state IDLE after release.
